// File: rtl/pipe_control.sv
// Decode and ID/EX, EX/WB pipeline control with a load-use hazard stall.
// Decode is combinational. All ex_* and wb_* outputs are registered.
module pipe_control #(
    parameter int OPC_W   = 6,
    parameter int FUNCT_W = 4,
    parameter int RA_W    = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [OPC_W-1:0]   opcode,
    input  logic [FUNCT_W-1:0] funct,
    input  logic [RA_W-1:0]    rs,
    input  logic [RA_W-1:0]    rt,
    input  logic [RA_W-1:0]    rd,
    input  logic               flush,
    output logic               in_ready,
    output logic               stall,
    output logic               ex_valid,
    output logic               ex_imm_sel,
    output logic               ex_shift,
    output logic               ex_mem_read,
    output logic [3:0]         ex_alu_op,
    output logic [RA_W-1:0]    ex_rd,
    output logic               ex_illegal,
    output logic               wb_valid,
    output logic               wb_reg_write,
    output logic               wb_mem_to_reg,
    output logic [RA_W-1:0]    wb_rd
);

    typedef enum logic [1:0] {CLS_RTYPE, CLS_ADDI, CLS_LOAD, CLS_ILLEGAL} instr_cls_e;

    localparam logic [OPC_W-1:0] OPC_LOAD = OPC_W'(6'b100011);

    instr_cls_e w_cls;
    logic [3:0] w_alu_op;
    logic       w_imm_sel, w_shift, w_mem_read, w_mem_to_reg, w_reg_write, w_illegal;
    logic       w_hazard, w_bubble;

    logic            r_ex_valid, r_ex_imm_sel, r_ex_shift, r_ex_mem_read, r_ex_illegal;
    logic            r_ex_reg_write, r_ex_mem_to_reg;
    logic [3:0]      r_ex_alu_op;
    logic [RA_W-1:0] r_ex_rd;
    logic            r_wb_valid, r_wb_reg_write, r_wb_mem_to_reg;
    logic [RA_W-1:0] r_wb_rd;

    always_comb begin
        w_cls = CLS_ILLEGAL;
        if (opcode == '0)
            w_cls = CLS_RTYPE;
        else if (opcode == '1)
            w_cls = CLS_ADDI;
        else if (opcode == OPC_LOAD)
            w_cls = CLS_LOAD;
    end

    always_comb begin
        w_alu_op     = '0;
        w_imm_sel    = 1'b0;
        w_shift      = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_to_reg = 1'b0;
        w_reg_write  = 1'b0;
        w_illegal    = 1'b0;
        case (w_cls)
            CLS_RTYPE: begin
                case (funct[3:0])
                    4'b0000: w_alu_op = 4'b1001;
                    4'b0010: w_alu_op = 4'b1010;
                    4'b1000: w_alu_op = 4'b0010;
                    4'b1010: w_alu_op = 4'b0100;
                    4'b1101: w_alu_op = 4'b0001;
                    default: w_alu_op = 4'b0000;
                endcase
                w_shift     = w_alu_op[3];
                w_reg_write = 1'b1;
            end
            CLS_ADDI: begin
                w_imm_sel   = 1'b1;
                w_reg_write = 1'b1;
            end
            CLS_LOAD: begin
                w_imm_sel    = 1'b1;
                w_mem_read   = 1'b1;
                w_mem_to_reg = 1'b1;
                w_reg_write  = 1'b1;
            end
            default: w_illegal = 1'b1;
        endcase
        // Writes to register 0 are architecturally discarded.
        if (rd == '0)
            w_reg_write = 1'b0;
    end

    assign w_hazard = in_valid && r_ex_valid && r_ex_mem_read && (r_ex_rd != '0) &&
                      ((r_ex_rd == rs) || ((r_ex_rd == rt) && (w_cls == CLS_RTYPE)));
    assign stall    = w_hazard;
    assign in_ready = ~w_hazard;
    assign w_bubble = flush || w_hazard || !in_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_valid      <= 1'b0;
            r_ex_imm_sel    <= 1'b0;
            r_ex_shift      <= 1'b0;
            r_ex_mem_read   <= 1'b0;
            r_ex_illegal    <= 1'b0;
            r_ex_reg_write  <= 1'b0;
            r_ex_mem_to_reg <= 1'b0;
            r_ex_alu_op     <= '0;
            r_ex_rd         <= '0;
        end else if (w_bubble) begin
            r_ex_valid      <= 1'b0;
            r_ex_imm_sel    <= 1'b0;
            r_ex_shift      <= 1'b0;
            r_ex_mem_read   <= 1'b0;
            r_ex_illegal    <= 1'b0;
            r_ex_reg_write  <= 1'b0;
            r_ex_mem_to_reg <= 1'b0;
            r_ex_alu_op     <= '0;
            r_ex_rd         <= '0;
        end else begin
            r_ex_valid      <= 1'b1;
            r_ex_imm_sel    <= w_imm_sel;
            r_ex_shift      <= w_shift;
            r_ex_mem_read   <= w_mem_read;
            r_ex_illegal    <= w_illegal;
            r_ex_reg_write  <= w_reg_write;
            r_ex_mem_to_reg <= w_mem_to_reg;
            r_ex_alu_op     <= w_alu_op;
            r_ex_rd         <= rd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_valid      <= 1'b0;
            r_wb_reg_write  <= 1'b0;
            r_wb_mem_to_reg <= 1'b0;
            r_wb_rd         <= '0;
        end else begin
            r_wb_valid      <= r_ex_valid;
            r_wb_reg_write  <= r_ex_reg_write & r_ex_valid;
            r_wb_mem_to_reg <= r_ex_mem_to_reg;
            r_wb_rd         <= r_ex_rd;
        end
    end

    assign ex_valid      = r_ex_valid;
    assign ex_imm_sel    = r_ex_imm_sel;
    assign ex_shift      = r_ex_shift;
    assign ex_mem_read   = r_ex_mem_read;
    assign ex_alu_op     = r_ex_alu_op;
    assign ex_rd         = r_ex_rd;
    assign ex_illegal    = r_ex_illegal;
    assign wb_valid      = r_wb_valid;
    assign wb_reg_write  = r_wb_reg_write;
    assign wb_mem_to_reg = r_wb_mem_to_reg;
    assign wb_rd         = r_wb_rd;

endmodule

// File: tb/tb_pipe_control.sv
// Self-checking bench for pipe_control: decode table, hazard, flush and reset sequences.
module tb_pipe_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, flush;
    logic [5:0] opcode;
    logic [3:0] funct;
    logic [4:0] rs, rt, rd;
    logic       in_ready, stall;
    logic       ex_valid, ex_imm_sel, ex_shift, ex_mem_read, ex_illegal;
    logic [3:0] ex_alu_op;
    logic [4:0] ex_rd;
    logic       wb_valid, wb_reg_write, wb_mem_to_reg;
    logic [4:0] wb_rd;

    pipe_control #(.OPC_W(6), .FUNCT_W(4), .RA_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .opcode(opcode), .funct(funct),
        .rs(rs), .rt(rt), .rd(rd), .flush(flush), .in_ready(in_ready), .stall(stall),
        .ex_valid(ex_valid), .ex_imm_sel(ex_imm_sel), .ex_shift(ex_shift),
        .ex_mem_read(ex_mem_read), .ex_alu_op(ex_alu_op), .ex_rd(ex_rd),
        .ex_illegal(ex_illegal), .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
        .wb_mem_to_reg(wb_mem_to_reg), .wb_rd(wb_rd)
    );

    always #5 clk = ~clk;

    localparam logic [5:0] OP_R = 6'b000000, OP_ADDI = 6'b111111, OP_LOAD = 6'b100011;

    typedef struct {
        logic       v;
        logic [3:0] alu;
        logic       imm, sh, mr, ill;
        logic [4:0] rd;
        logic       wrw, m2r;
    } exp_t;

    typedef struct {
        logic [5:0] opc;
        logic [3:0] fn;
        logic [4:0] rd;
        exp_t       e;
    } vec_t;

    exp_t exq[$];
    exp_t wbq[$];
    int   n_pass = 0;
    int   n_total = 0;

    function automatic exp_t mk(input logic v, input logic [3:0] alu, input logic imm, sh, mr, ill,
                                input logic [4:0] r, input logic wrw, m2r);
        exp_t e;
        e.v = v; e.alu = alu; e.imm = imm; e.sh = sh; e.mr = mr; e.ill = ill;
        e.rd = r; e.wrw = wrw; e.m2r = m2r;
        return e;
    endfunction

    function automatic vec_t mv(input logic [5:0] opc, input logic [3:0] fn, input logic [4:0] r,
                                input logic [3:0] alu, input logic imm, sh, mr, ill, wrw, m2r);
        vec_t t;
        t.opc = opc; t.fn = fn; t.rd = r;
        t.e = mk(1'b1, alu, imm, sh, mr, ill, r, wrw, m2r);
        return t;
    endfunction

    function automatic exp_t bubble();
        return mk(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    task automatic drive(input logic v, input logic [5:0] opc, input logic [3:0] fn,
                         input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                         input logic fl);
        in_valid = v; opcode = opc; funct = fn; rs = s; rt = t; rd = d; flush = fl;
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (wbq.size() > 0) begin
            e = wbq.pop_front();
            chk("wb_stage", {19'd0, wb_valid, wb_reg_write, wb_mem_to_reg, wb_rd},
                {19'd0, e.v, e.wrw, e.m2r, e.rd});
        end
        if (exq.size() > 0) begin
            e = exq.pop_front();
            chk("ex_stage", {19'd0, ex_valid, ex_alu_op, ex_imm_sel, ex_shift, ex_mem_read, ex_illegal, ex_rd},
                {19'd0, e.v, e.alu, e.imm, e.sh, e.mr, e.ill, e.rd});
            wbq.push_back(e);
        end
    endtask

    task automatic idle_drain();
        drive(1'b0, 6'd0, 4'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        exq.push_back(bubble());
        tick();
        tick();
    endtask

    vec_t tbl[12];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //                opc      fn     rd     alu    imm   sh    mr    ill   wrw   m2r
        tbl[0]  = mv(OP_R,    4'h0, 5'd3,  4'h9, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        tbl[1]  = mv(OP_R,    4'h2, 5'd4,  4'hA, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        tbl[2]  = mv(OP_R,    4'h8, 5'd6,  4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tbl[3]  = mv(OP_R,    4'hA, 5'd7,  4'h4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tbl[4]  = mv(OP_R,    4'hD, 5'd8,  4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tbl[5]  = mv(OP_R,    4'h7, 5'd9,  4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tbl[6]  = mv(OP_ADDI, 4'h0, 5'd0,  4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tbl[7]  = mv(OP_ADDI, 4'h5, 5'd10, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tbl[8]  = mv(OP_LOAD, 4'h0, 5'd5,  4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        tbl[9]  = mv(6'h15,   4'h0, 5'd11, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tbl[10] = mv(OP_R,    4'h0, 5'd0,  4'h9, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tbl[11] = mv(OP_LOAD, 4'h0, 5'd0,  4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);

        rst_n = 1'b0;
        drive(1'b0, 6'd0, 4'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        #12;
        chk("reset_ex", {19'd0, ex_valid, ex_alu_op, ex_imm_sel, ex_shift, ex_mem_read, ex_illegal, ex_rd}, 32'd0);
        chk("reset_wb", {23'd0, wb_valid, wb_reg_write, wb_mem_to_reg, wb_rd}, 32'd0);
        chk("reset_ready", {30'd0, stall, in_ready}, 32'd1);
        #1 rst_n = 1'b1;

        // Back-to-back decode table; rs/rt are zero so no hazard can arise.
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, tbl[i].opc, tbl[i].fn, 5'd0, 5'd0, tbl[i].rd, 1'b0);
            exq.push_back(tbl[i].e);
            tick();
        end
        idle_drain();

        // Load-use on rs: one-cycle stall, then the R-type enters ID/EX.
        drive(1'b1, OP_LOAD, 4'h0, 5'd0, 5'd0, 5'd5, 1'b0);
        exq.push_back(mk(1'b1, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1));
        tick();
        drive(1'b1, OP_R, 4'h0, 5'd5, 5'd0, 5'd3, 1'b0);
        #1;
        chk("loaduse_stall", {30'd0, stall, in_ready}, 32'd2);
        exq.push_back(bubble());
        tick();
        chk("loaduse_release", {30'd0, stall, in_ready}, 32'd1);
        exq.push_back(mk(1'b1, 4'h9, 1'b0, 1'b1, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0));
        tick();
        idle_drain();

        // Load then ADDI with rt matching: rt is not a source for ADDI, no stall.
        drive(1'b1, OP_LOAD, 4'h0, 5'd0, 5'd0, 5'd5, 1'b0);
        exq.push_back(mk(1'b1, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1));
        tick();
        drive(1'b1, OP_ADDI, 4'h0, 5'd2, 5'd5, 5'd6, 1'b0);
        #1;
        chk("addi_rt_nostall", {30'd0, stall, in_ready}, 32'd1);
        exq.push_back(mk(1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd6, 1'b1, 1'b0));
        tick();
        idle_drain();

        // Load then R-type using rt: hazard on rt for R-type.
        drive(1'b1, OP_LOAD, 4'h0, 5'd0, 5'd0, 5'd5, 1'b0);
        exq.push_back(mk(1'b1, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1));
        tick();
        drive(1'b1, OP_R, 4'h8, 5'd1, 5'd5, 5'd4, 1'b0);
        #1;
        chk("rtype_rt_stall", {30'd0, stall, in_ready}, 32'd2);
        // Flush during the stall: the R-type is discarded for good.
        flush = 1'b1;
        exq.push_back(bubble());
        tick();
        drive(1'b0, 6'd0, 4'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        exq.push_back(bubble());
        tick();
        tick();

        // Flush on an otherwise clean instruction.
        drive(1'b1, OP_ADDI, 4'h0, 5'd0, 5'd0, 5'd7, 1'b1);
        exq.push_back(bubble());
        tick();
        idle_drain();

        // Asynchronous reset with both stages full, then first post-reset edge.
        exq.delete();
        wbq.delete();
        drive(1'b1, OP_ADDI, 4'h0, 5'd0, 5'd0, 5'd9, 1'b0);
        tick();
        drive(1'b1, OP_ADDI, 4'h0, 5'd0, 5'd0, 5'd10, 1'b0);
        tick();
        chk("full_before_reset", {30'd0, ex_valid, wb_valid}, 32'd3);
        #3 rst_n = 1'b0;
        #1;
        chk("async_reset_ex", {26'd0, ex_valid, ex_rd}, 32'd0);
        chk("async_reset_wb", {25'd0, wb_valid, wb_reg_write, wb_rd}, 32'd0);
        drive(1'b1, OP_ADDI, 4'h0, 5'd0, 5'd0, 5'd12, 1'b0);
        #2 rst_n = 1'b1;
        exq.push_back(mk(1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd12, 1'b1, 1'b0));
        tick();
        idle_drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pipe_control.md
PIPE_CONTROL -- requirements
Module: pipe_control

Interface
REQ-001 Parameter: OPC_W, default 6, opcode width; FUNCT_W, default 4, funct width (minimum 4; only bits [3:0] are decoded).
REQ-002 Parameter: RA_W, default 5, register-address width.
REQ-003 Port: clk  in  1  the single clock; all state is updated on the rising edge.
REQ-004 Port: rst_n  in  1  asynchronous, active-low reset.
REQ-005 Port: in_valid  in  1  the decode-stage instruction is valid.
REQ-006 Port: opcode  in  OPC_W  instruction opcode.
REQ-007 Port: funct  in  FUNCT_W  R-type function field.
REQ-008 Port: rs, rt, rd  in  RA_W each  source and destination register addresses.
REQ-009 Port: flush  in  1  kill the decode-stage instruction.
REQ-010 Port: in_ready  out  1  the decode-stage instruction is accepted this cycle.
REQ-011 Port: stall  out  1  a load-use hazard is detected this cycle.
REQ-012 Port: ex_valid, ex_imm_sel, ex_shift, ex_mem_read  out  1 each  ID/EX stage controls.
REQ-013 Port: ex_alu_op  out  4  ID/EX ALU operation.
REQ-014 Port: ex_rd  out  RA_W  ID/EX destination register.
REQ-015 Port: ex_illegal  out  1  one-cycle pulse marking an accepted undefined opcode.
REQ-016 Port: wb_valid, wb_reg_write, wb_mem_to_reg  out  1 each  EX/WB stage controls.
REQ-017 Port: wb_rd  out  RA_W  EX/WB destination register.

Function
REQ-018 Decode shall be combinational from opcode and funct; all ex_* and wb_* outputs shall be registered.
REQ-019 Opcode all-ones (ADDI) shall decode as: alu_op 0000, imm_sel 1, shift 0, reg_write 1, mem_read 0.
REQ-020 Opcode all-zeros (R-type) shall decode as: imm_sel 0, reg_write 1, mem_read 0.
REQ-021 R-type alu_op shall be set from funct[3:0]: 0000->1001, 0010->1010, 1000->0010, 1010->0100, 1101->0001, any other value->0000.
REQ-022 For R-type, shift shall equal alu_op[3].
REQ-023 Opcode 100011 (LOAD) shall decode as: alu_op 0000, imm_sel 1, mem_read 1, reg_write 1, mem_to_reg 1.
REQ-024 Any other opcode shall decode as all-zero controls and shall set ex_illegal for one cycle.
REQ-025 A decode stage whose destination is rd==0 shall have reg_write forced to 0.
REQ-026 stall shall be 1 when all of the following hold: in_valid=1, ex_valid=1, ex_mem_read=1, ex_rd!=0, and ex_rd equals rs, or ex_rd equals rt with the decode-stage instruction being R-type.
REQ-027 in_ready shall equal the inverse of stall.
REQ-028 On a clock edge with flush=1, ID/EX shall load a bubble and the input shall be discarded; flush shall take priority over stall.
REQ-029 On a clock edge with stall=1, ID/EX shall load a bubble and the decode-stage instruction shall be held by upstream.
REQ-030 On a clock edge with in_valid=0, ID/EX shall load a bubble.
REQ-031 A bubble shall be: ex_valid=0, all ex_* controls 0, ex_illegal 0.
REQ-032 Otherwise ID/EX shall capture the decoded controls, rd, and ex_valid=1.
REQ-033 EX/WB shall advance every cycle, unconditionally, from ID/EX.
REQ-034 EX/WB shall set wb_reg_write = ex_reg_write AND ex_valid.
REQ-035 Latency shall be: the instruction accepted at edge N appears on ex_* after edge N and on wb_* after edge N+1.
REQ-036 A stall shall last exactly one cycle, because the load leaves ID/EX after one cycle.

Reset
REQ-037 While rst_n=0, all ex_* and wb_* registers shall clear to 0 immediately, without waiting for clk.
REQ-038 Reset asserted mid-pipeline shall discard all in-flight instructions.
REQ-039 The first accepted instruction after reset deassertion shall be the one presented at the first rising edge with rst_n=1.

Verification
REQ-040 Scenario: R-type, funct=0000, rd=3 -> next cycle ex_alu_op=1001, ex_shift=1, ex_valid=1; following cycle wb_reg_write=1, wb_rd=3.
REQ-041 Scenario: ADDI, rd=0 -> ex_alu_op=0000, ex_imm_sel=1; then wb_reg_write=0.
REQ-042 Scenario: LOAD rd=5 followed by R-type rs=5 -> stall=1 and in_ready=0 for one cycle; ex_valid=0 (bubble); R-type reaches ID/EX one cycle later.
REQ-043 Scenario: LOAD rd=5 followed by ADDI rt=5, rs=2 -> no stall.
REQ-044 Scenario: opcode 010101 -> ex_illegal=1 for one cycle and all controls 0; flush asserted during a stall -> bubble, flush wins.
REQ-045 Scenario: rst_n pulled low between clock edges with the pipeline full -> ex_valid=0 and wb_valid=0 immediately.
